// File: rtl/afe_pkg.sv
// ---------------------------------------------------------------------------
// afe_pkg
// Shared definitions for the AFE4403 SPI master:
//   - data_part byte-index encodings (address, high, mid, low)
//   - FSM state encoding for afe_spi_master
//   - frame length of one AFE4403 register access
// ---------------------------------------------------------------------------
package afe_pkg;

    localparam int AFE_FRAME_BITS = 32;

    localparam logic [1:0] DP_ADDR = 2'd0;
    localparam logic [1:0] DP_HIGH = 2'd1;
    localparam logic [1:0] DP_MID  = 2'd2;
    localparam logic [1:0] DP_LOW  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } afe_state_e;

endpackage

// File: rtl/afe_sclk_gen.sv
// ---------------------------------------------------------------------------
// afe_sclk_gen
// SPI mode-0 clock generator. While run is high, spi_sclk toggles every
// SCLK_HALF div_clk cycles, starting low. While run is low the divider is
// held at its reload value and sclk is forced low, so every byte starts with
// a full low half-period.
// Ports:
//   div_clk  in   system clock
//   rst_n    in   async active-low reset
//   run      in   enable toggling (high only while shifting)
//   sclk_o   out  registered SPI clock
//   rise_o   out  high in the cycle before sclk rises (sclk rises at its end)
//   fall_o   out  high in the cycle before sclk falls
// ---------------------------------------------------------------------------
module afe_sclk_gen #(
    parameter int SCLK_HALF = 2
) (
    input  logic div_clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [15:0] DIV_RELOAD = 16'(SCLK_HALF - 1);

    logic [15:0] div_cnt_q;
    logic        sclk_q;
    logic        tc;

    assign tc = (div_cnt_q == 16'd0);

    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= DIV_RELOAD;
            sclk_q    <= 1'b0;
        end else if (!run) begin
            div_cnt_q <= DIV_RELOAD;
            sclk_q    <= 1'b0;
        end else if (tc) begin
            div_cnt_q <= DIV_RELOAD;
            sclk_q    <= ~sclk_q;
        end else begin
            div_cnt_q <= div_cnt_q - 16'd1;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = run && tc && !sclk_q;
    assign fall_o = run && tc && sclk_q;

endmodule

// File: rtl/afe_spi_master.sv
// ---------------------------------------------------------------------------
// afe_spi_master
// Serial engine for AFE4403 register frames: address byte followed by a
// 24-bit payload (high, mid, low), MSB first, SPI mode 0.
// Write frames shift the four bytes presented on tx_data; read frames shift
// the address, then zeros, while capturing 24 bits from spi_miso.
// Ports:
//   div_clk, rst_n      clock, async active-low reset
//   wr_en, rd_en        frame requests (IDLE only, write wins)
//   tx_data             byte selected by data_part (upstream lookup)
//   data_part           current byte index
//   spi_done            pulse at the end of each byte
//   flash               pulse when the CS gap ends
//   busy                high outside IDLE
//   rx_data, rx_valid   last read payload and its update strobe
//   spi_ste/sclk/mosi   SPI outputs; spi_miso SPI input
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for wr_en/rd_en, spi_ste high
// SETUP    | spi_ste low, CS_SETUP cycles before the first byte
// LOAD     | capture tx_data (or 0x00 for read payload) into shift register
// SHIFT    | 8 SCLK periods: sample MISO on rise, shift MOSI on fall
// DONE     | spi_done pulse; next byte or close the frame
// GAP      | spi_ste high for CS_GAP cycles, then flash and back to IDLE
// ---------------------------------------------------------------------------
module afe_spi_master
    import afe_pkg::*;
#(
    parameter int SCLK_HALF = 2,
    parameter int CS_SETUP  = 2,
    parameter int CS_GAP    = 4
) (
    input  logic        div_clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  tx_data,
    output logic [1:0]  data_part,
    output logic        spi_done,
    output logic        flash,
    output logic        busy,
    output logic [23:0] rx_data,
    output logic        rx_valid,
    output logic        spi_ste,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int          BYTE_BITS   = AFE_FRAME_BITS / 4;
    localparam logic [2:0]  LAST_BIT    = 3'(BYTE_BITS - 1);
    localparam logic [15:0] SETUP_LOAD  = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(CS_GAP - 1);

    afe_state_e  state_q;
    logic        wr_mode_q;
    logic [1:0]  data_part_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  tx_sh_q;
    logic [23:0] rx_sh_q;
    logic [23:0] rx_data_q;
    logic        rx_valid_q;
    logic        spi_done_q;
    logic        flash_q;
    logic        busy_q;
    logic        ste_q;

    logic        sclk_run;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        payload_byte;

    assign sclk_run     = (state_q == ST_SHIFT);
    assign payload_byte = (data_part_q != DP_ADDR);

    afe_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .div_clk (div_clk),
        .rst_n   (rst_n),
        .run     (sclk_run),
        .sclk_o  (spi_sclk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_mode_q   <= 1'b0;
            data_part_q <= DP_ADDR;
            timer_q     <= 16'd0;
            bit_cnt_q   <= 3'd0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 24'h0;
            rx_data_q   <= 24'h0;
            rx_valid_q  <= 1'b0;
            spi_done_q  <= 1'b0;
            flash_q     <= 1'b0;
            busy_q      <= 1'b0;
            ste_q       <= 1'b1;
        end else begin
            spi_done_q <= 1'b0;
            flash_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_en || rd_en) begin
                        wr_mode_q   <= wr_en;
                        data_part_q <= DP_ADDR;
                        ste_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        timer_q     <= SETUP_LOAD;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == 16'd0) begin
                        state_q <= ST_LOAD;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                ST_LOAD: begin
                    // read payload bytes clock out zeros while MISO is captured
                    tx_sh_q   <= (!wr_mode_q && payload_byte) ? 8'h00 : tx_data;
                    bit_cnt_q <= 3'd0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise && !wr_mode_q && payload_byte) begin
                        rx_sh_q <= {rx_sh_q[22:0], spi_miso};
                    end
                    if (sclk_fall) begin
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q    <= ST_DONE;
                            spi_done_q <= 1'b1;
                            // rx_valid is registered alongside spi_done so both
                            // are visible in the DONE cycle of the last byte
                            if (!wr_mode_q && data_part_q == DP_LOW) begin
                                rx_data_q  <= rx_sh_q;
                                rx_valid_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (data_part_q == DP_LOW) begin
                        ste_q       <= 1'b1;
                        data_part_q <= DP_ADDR;
                        timer_q     <= GAP_LOAD;
                        state_q     <= ST_GAP;
                    end else begin
                        data_part_q <= data_part_q + 2'd1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_GAP: begin
                    if (timer_q == 16'd0) begin
                        flash_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_part = data_part_q;
    assign spi_done  = spi_done_q;
    assign flash     = flash_q;
    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign spi_ste   = ste_q;
    assign spi_mosi  = tx_sh_q[7];

endmodule

// File: tb/tb_afe_spi_master.sv
// ---------------------------------------------------------------------------
// tb_afe_spi_master
// Directed bench for afe_spi_master with default parameters
// (SCLK_HALF=2, CS_SETUP=2, CS_GAP=4 -> 143-cycle frame latency).
// A negedge monitor captures MOSI on SCLK rising edges, plays a MISO slave
// that shifts on SCLK falling edges, and counts strobes. tx_data comes from
// a combinational lookup of data_part into the current 32-bit frame word.
// ---------------------------------------------------------------------------
module tb_afe_spi_master;

    logic        div_clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  tx_data;
    logic [1:0]  data_part;
    logic        spi_done;
    logic        flash;
    logic        busy;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic        spi_ste;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    afe_spi_master dut (
        .div_clk   (div_clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .tx_data   (tx_data),
        .data_part (data_part),
        .spi_done  (spi_done),
        .flash     (flash),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .spi_ste   (spi_ste),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    localparam int EXP_LAT = 143;
    localparam int GAP_CYC = 4;

    initial begin
        div_clk = 1'b0;
        forever #5 div_clk = ~div_clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // upstream byte lookup
    logic [31:0] tx_word = 32'h0;
    always_comb begin
        tx_data = 8'h00;
        case (data_part)
            2'd0: tx_data = tx_word[31:24];
            2'd1: tx_data = tx_word[23:16];
            2'd2: tx_data = tx_word[15:8];
            2'd3: tx_data = tx_word[7:0];
            default: tx_data = 8'h00;
        endcase
    end

    int cyc = 0;
    always @(posedge div_clk) cyc++;

    // monitor and MISO slave
    logic [31:0] miso_frame = 32'h0;
    logic [31:0] miso_sh    = 32'h0;
    logic [31:0] mosi_cap   = 32'h0;
    logic [7:0]  done_seq   = 8'h0;
    logic        sclk_prev  = 1'b0;
    logic        ste_prev   = 1'b1;
    logic        busy_prev  = 1'b0;
    int rise_cnt = 0, done_cnt = 0, flash_cnt = 0, rxv_cnt = 0;
    int ste_bad = 0, both_bad = 0, rxv_bad = 0;
    int ste_hi_run = 0, gap_run = 0, start_edge = 0, flash_edge = 0;

    always @(negedge div_clk) begin
        if (spi_sclk && !sclk_prev) begin
            mosi_cap = {mosi_cap[30:0], spi_mosi};
            rise_cnt++;
            if (spi_ste) ste_bad++;
        end
        if (!spi_sclk && sclk_prev) miso_sh = {miso_sh[30:0], 1'b0};
        if (!spi_ste && ste_prev) begin
            miso_sh    = miso_frame;
            ste_hi_run = 0;
        end
        spi_miso = miso_sh[31];
        if (flash) begin
            flash_cnt++;
            flash_edge = cyc;
            gap_run    = ste_hi_run;
        end
        if (spi_ste) ste_hi_run++;
        if (busy && !busy_prev) start_edge = cyc;
        if (spi_done) begin
            done_cnt++;
            done_seq = {done_seq[5:0], data_part};
            if (flash) both_bad++;
        end
        if (rx_valid) begin
            rxv_cnt++;
            if (!(spi_done && data_part == 2'd3)) rxv_bad++;
        end
        sclk_prev = spi_sclk;
        ste_prev  = spi_ste;
        busy_prev = busy;
    end

    task automatic wait_flash(input int f0, input string tag);
        int n;
        n = 0;
        while (flash_cnt == f0 && n < 400) begin
            @(posedge div_clk); #1;
            n++;
        end
        chk({tag, " flash_seen"}, 32'(flash_cnt != f0), 32'd1);
    endtask

    function automatic logic [31:0] b2b_word(input int k);
        logic [7:0] a;
        a = 8'(k);
        return {a, a ^ 8'h5A, ~a, 8'(k * 7)};
    endfunction

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [31:0] word;
        logic [23:0] pl;
        logic [31:0] exp_mosi;
        int          exp_rxv;
        logic [23:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, d0, v0, f0, n, lat;
        logic [23:0] rx_keep;

        vecs[0] = '{"wr_afe_init",  1'b1, 1'b0, 32'h010017C0, 24'h000000, 32'h010017C0, 0, 24'h000000};
        vecs[1] = '{"rd_2a",        1'b0, 1'b1, 32'h2AFFFFFF, 24'h123456, 32'h2A000000, 1, 24'h123456};
        vecs[2] = '{"wr_rd_both",   1'b1, 1'b1, 32'h5AA53CC3, 24'h654321, 32'h5AA53CC3, 0, 24'h123456};
        vecs[3] = '{"rd_81",        1'b0, 1'b1, 32'h81C3C3C3, 24'hABCDEF, 32'h81000000, 1, 24'hABCDEF};
        vecs[4] = '{"wr_edges",     1'b1, 1'b0, 32'h80000001, 24'hFFFFFF, 32'h80000001, 0, 24'hABCDEF};

        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #12;
        chk("rst spi_ste",   32'(spi_ste),   32'd1);
        chk("rst spi_sclk",  32'(spi_sclk),  32'd0);
        chk("rst spi_mosi",  32'(spi_mosi),  32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst data_part", 32'(data_part), 32'd0);
        chk("rst rx_data",   32'(rx_data),   32'd0);
        chk("rst strobes",   32'({spi_done, flash, rx_valid}), 32'd0);
        @(posedge div_clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge div_clk);
        #1;
        chk("idle busy", 32'(busy), 32'd0);

        // table-driven single frames
        for (int i = 0; i < 5; i++) begin
            tx_word    = vecs[i].word;
            miso_frame = {8'h00, vecs[i].pl};
            r0 = rise_cnt; d0 = done_cnt; v0 = rxv_cnt; f0 = flash_cnt;
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            @(posedge div_clk); #1;
            wr_en = 1'b0;
            rd_en = 1'b0;
            wait_flash(f0, vecs[i].name);
            lat = flash_edge - start_edge + 1;
            chk({vecs[i].name, " mosi"},     mosi_cap,            vecs[i].exp_mosi);
            chk({vecs[i].name, " rises"},    32'(rise_cnt - r0),  32'd32);
            chk({vecs[i].name, " dones"},    32'(done_cnt - d0),  32'd4);
            chk({vecs[i].name, " done_seq"}, 32'(done_seq),       32'h1B);
            chk({vecs[i].name, " rx_valid"}, 32'(rxv_cnt - v0),   32'(vecs[i].exp_rxv));
            chk({vecs[i].name, " rx_data"},  32'(rx_data),        32'(vecs[i].exp_rx));
            chk({vecs[i].name, " latency"},  32'(lat),            32'(EXP_LAT));
            chk({vecs[i].name, " gap"},      32'(gap_run),        32'(GAP_CYC));
            chk({vecs[i].name, " busy_end"}, 32'(busy),           32'd0);
            repeat (2) @(posedge div_clk);
            #1;
        end

        // rd_en raised mid-frame is ignored
        tx_word    = 32'hC3A50F96;
        miso_frame = 32'h00FEDCBA;
        rx_keep    = rx_data;
        v0 = rxv_cnt; f0 = flash_cnt;
        wr_en = 1'b1;
        @(posedge div_clk); #1;
        wr_en = 1'b0;
        repeat (60) @(posedge div_clk);
        #1;
        rd_en = 1'b1;
        repeat (40) @(posedge div_clk);
        #1;
        rd_en = 1'b0;
        wait_flash(f0, "rd_mid");
        chk("rd_mid mosi",     mosi_cap,               32'hC3A50F96);
        chk("rd_mid rx_valid", 32'(rxv_cnt - v0),      32'd0);
        chk("rd_mid rx_data",  32'(rx_data),           32'(rx_keep));
        repeat (5) @(posedge div_clk);
        #1;
        chk("rd_mid no_restart", 32'(busy), 32'd0);

        // back-to-back frames from the init sequencer model
        tx_word = b2b_word(0);
        r0 = rise_cnt; d0 = done_cnt; f0 = flash_cnt;
        wr_en = 1'b1;
        for (int k = 0; k < 33; k++) begin
            if (k == 32) wr_en = 1'b0;
            wait_flash(f0, $sformatf("b2b%0d", k));
            lat = flash_edge - start_edge + 1;
            chk($sformatf("b2b%0d mosi", k),    mosi_cap,           b2b_word(k));
            chk($sformatf("b2b%0d rises", k),   32'(rise_cnt - r0), 32'd32);
            chk($sformatf("b2b%0d dones", k),   32'(done_cnt - d0), 32'd4);
            chk($sformatf("b2b%0d latency", k), 32'(lat),           32'(EXP_LAT));
            chk($sformatf("b2b%0d gap", k),     32'(gap_run >= GAP_CYC), 32'd1);
            tx_word = b2b_word(k + 1);
            r0 = rise_cnt; d0 = done_cnt; f0 = flash_cnt;
        end
        repeat (5) @(posedge div_clk);
        #1;
        chk("b2b stops", 32'(busy), 32'd0);

        // reset during byte 2 (data_part=10)
        tx_word = 32'h12345678;
        d0 = done_cnt; f0 = flash_cnt;
        wr_en = 1'b1;
        @(posedge div_clk); #1;
        wr_en = 1'b0;
        n = 0;
        while (!(data_part == 2'd2 && spi_sclk) && n < 300) begin
            @(posedge div_clk); #1;
            n++;
        end
        chk("rstmid reached", 32'(data_part == 2'd2 && spi_sclk), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid spi_ste",   32'(spi_ste),   32'd1);
        chk("rstmid spi_sclk",  32'(spi_sclk),  32'd0);
        chk("rstmid busy",      32'(busy),      32'd0);
        chk("rstmid data_part", 32'(data_part), 32'd0);
        chk("rstmid rx_data",   32'(rx_data),   32'd0);
        repeat (3) @(posedge div_clk);
        #1;
        rst_n = 1'b1;
        repeat (200) @(posedge div_clk);
        #1;
        chk("rstmid dones", 32'(done_cnt - d0),  32'd2);
        chk("rstmid flash", 32'(flash_cnt - f0), 32'd0);
        chk("rstmid idle",  32'(busy),           32'd0);

        chk("ste_low_on_sclk",   32'(ste_bad),  32'd0);
        chk("done_flash_excl",   32'(both_bad), 32'd0);
        chk("rx_valid_aligned",  32'(rxv_bad),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
